// File: rtl/filt_pkg.sv
// Shared defaults and reader FSM encoding for the sample ring buffer.
// Imported by the ring-buffer writer and reader so both agree on geometry.
package filt_pkg;
   localparam int M_DEF         = 23;
   localparam int ADDR_SIZE_DEF = 5;
   localparam int DATA_SIZE_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_WR,
      ST_READ,
      ST_DRAIN,
      ST_FIN
   } rd_state_t;
endpackage

// File: rtl/skid_buf.sv
// Two-entry fall-through buffer: an empty buffer passes input to output in the same cycle.
// Backpressure: o_spare says a word arriving next cycle can still be stored.
module skid_buf #(
   parameter int W = 22
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_in_vld,
   input  logic [W-1:0] i_in_dat,
   output logic         o_in_rdy,
   output logic         o_out_vld,
   output logic [W-1:0] o_out_dat,
   input  logic         i_out_rdy,
   output logic         o_spare
);
   logic [W-1:0] r_mem [2];
   logic         r_rd_ptr;
   logic         r_wr_ptr;
   logic [1:0]   r_cnt;
   logic [1:0]   w_cnt_nxt;
   logic         w_empty;
   logic         w_push;
   logic         w_pop_mem;

   assign w_empty   = (r_cnt == 2'd0);
   assign o_in_rdy  = (r_cnt != 2'd2);
   assign o_out_vld = !w_empty || i_in_vld;
   assign o_out_dat = !w_empty ? r_mem[r_rd_ptr] : (i_in_vld ? i_in_dat : '0);

   // A word offered while empty and accepted downstream never touches storage.
   assign w_pop_mem = !w_empty && i_out_rdy;
   assign w_push    = i_in_vld && o_in_rdy && !(w_empty && i_out_rdy);
   assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop_mem};
   assign o_spare   = (w_cnt_nxt != 2'd2);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_in_dat;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop_mem) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_cnt <= w_cnt_nxt;
      end
   end
endmodule

// File: rtl/rbuf_reader.sv
// Reads one M-sample window newest-first from the ring BRAM; first word 2 cycles after start.
// Issue stalls on writer ownership or downstream backpressure; words never dropped or repeated.
module rbuf_reader
   import filt_pkg::*;
#(
   parameter int M         = M_DEF,
   parameter int ADDR_SIZE = ADDR_SIZE_DEF,
   parameter int DATA_SIZE = DATA_SIZE_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [ADDR_SIZE-1:0] i_wr_ptr,
   input  logic                 i_wr_busy,
   output logic [ADDR_SIZE-1:0] o_bram_addr,
   output logic                 o_bram_en,
   input  logic [DATA_SIZE-1:0] i_bram_q,
   output logic [DATA_SIZE-1:0] o_out_data,
   output logic [ADDR_SIZE-1:0] o_out_idx,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic                 o_out_last,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_err
);
   localparam int                   W      = DATA_SIZE + ADDR_SIZE + 1;
   localparam logic [ADDR_SIZE-1:0] K_LAST = ADDR_SIZE'(M - 1);

   rd_state_t            r_state;
   rd_state_t            w_state_nxt;
   logic [ADDR_SIZE-1:0] r_addr;
   logic [ADDR_SIZE-1:0] r_k;
   logic [ADDR_SIZE-1:0] r_if_idx;
   logic                 r_if_vld;
   logic                 r_if_last;
   logic                 r_err;
   logic [ADDR_SIZE-1:0] w_addr_dec;
   logic                 w_ptr_bad;
   logic                 w_issue;
   logic                 w_spare;
   logic                 w_in_rdy;
   logic                 w_xfer;
   logic [W-1:0]         w_in_dat;
   logic [W-1:0]         w_out_dat;

   assign w_ptr_bad  = (32'(i_wr_ptr) >= 32'(M));
   assign w_addr_dec = (r_addr == '0) ? K_LAST : (r_addr - ADDR_SIZE'(1));
   assign w_issue    = (r_state == ST_READ) && !i_wr_busy && w_spare && w_in_rdy;
   assign w_xfer     = o_out_valid && i_out_ready;
   assign w_in_dat   = r_if_vld ? {i_bram_q, r_if_idx, r_if_last} : '0;

   skid_buf #(.W(W)) u_skid (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_in_vld  (r_if_vld),
      .i_in_dat  (w_in_dat),
      .o_in_rdy  (w_in_rdy),
      .o_out_vld (o_out_valid),
      .o_out_dat (w_out_dat),
      .i_out_rdy (i_out_ready),
      .o_spare   (w_spare)
   );

   assign {o_out_data, o_out_idx, o_out_last} = w_out_dat;
   assign o_bram_en   = w_issue;
   assign o_bram_addr = r_addr;
   assign o_busy      = (r_state != ST_IDLE);
   assign o_done      = (r_state == ST_FIN);
   assign o_err       = (r_state == ST_FIN) && r_err;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               if (w_ptr_bad)      w_state_nxt = ST_FIN;
               else if (i_wr_busy) w_state_nxt = ST_WAIT_WR;
               else                w_state_nxt = ST_READ;
            end
         end
         ST_WAIT_WR: if (!i_wr_busy)                w_state_nxt = ST_READ;
         ST_READ:    if (w_issue && r_k == K_LAST)  w_state_nxt = ST_DRAIN;
         ST_DRAIN:   if (w_xfer && o_out_last)      w_state_nxt = ST_FIN;
         ST_FIN:                                    w_state_nxt = ST_IDLE;
         default:                                   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_addr    <= '0;
         r_k       <= '0;
         r_err     <= 1'b0;
         r_if_vld  <= 1'b0;
         r_if_idx  <= '0;
         r_if_last <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_if_vld  <= w_issue;
         r_if_idx  <= r_k;
         r_if_last <= (r_k == K_LAST);
         // An out-of-range pointer is never loaded, so the address port stays below M.
         if (r_state == ST_IDLE && i_start) begin
            r_k   <= '0;
            r_err <= w_ptr_bad;
            if (!w_ptr_bad) r_addr <= i_wr_ptr;
         end else if (w_issue) begin
            r_k    <= r_k + ADDR_SIZE'(1);
            r_addr <= w_addr_dec;
         end
      end
   end
endmodule
